// File: rtl/z80_pkg.sv
// Shared z80 core types: bus operation codes, T-state encoding and default bus widths.
package z80_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_FETCH,
        OP_MEM_RD,
        OP_MEM_WR,
        OP_IO_RD,
        OP_IO_WR
    } bus_op_t;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_T1,
        TS_T2,
        TS_TW,
        TS_T3,
        TS_T4
    } tstate_t;

    function automatic logic is_io(input bus_op_t op);
        return (op == OP_IO_RD) || (op == OP_IO_WR);
    endfunction

    function automatic logic is_write(input bus_op_t op);
        return (op == OP_MEM_WR) || (op == OP_IO_WR);
    endfunction

    // Reads that capture data_in at the end of T3 (fetch captures earlier).
    function automatic logic is_read(input bus_op_t op);
        return (op == OP_MEM_RD) || (op == OP_IO_RD);
    endfunction

endpackage

// File: rtl/z80_bus_sequencer.sv
// Machine-cycle sequencer: walks T1/T2/TW/T3/T4 for fetch, memory and I/O cycles and
// decodes the active-low bus strobes from the registered T-state and latched operation.
module z80_bus_sequencer
    import z80_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned IO_AUTO_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              req_valid,
    input  bus_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] refresh_addr,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    input  logic              WAIT_L,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_oe,
    output logic              M1_L,
    output logic              MREQ_L,
    output logic              IORQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic              RFSH_L
);

    localparam logic       HAS_AUTO  = (IO_AUTO_WAIT != 0);
    // Counter holds the auto waits still owed after the first TW is entered.
    localparam logic [1:0] AUTO_LOAD = HAS_AUTO ? 2'(IO_AUTO_WAIT - 1) : 2'd0;

    tstate_t           state_q, state_d;
    bus_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        auto_q, auto_d;
    logic              done_q, done_d;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= TS_IDLE;
            op_q    <= OP_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            auto_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        auto_d  = auto_q;
        done_d  = 1'b0;
        unique case (state_q)
            TS_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = TS_T1;
                end
            end
            TS_T1: state_d = TS_T2;
            TS_T2: begin
                if (is_io(op_q) && HAS_AUTO) begin
                    state_d = TS_TW;
                    auto_d  = AUTO_LOAD;
                end else if (!WAIT_L) begin
                    state_d = TS_TW;
                end else begin
                    state_d = TS_T3;
                    if (op_q == OP_FETCH) rdata_d = data_in;
                end
            end
            TS_TW: begin
                if (auto_q != 2'd0) begin
                    auto_d = auto_q - 2'd1;
                end else if (WAIT_L) begin
                    state_d = TS_T3;
                    if (op_q == OP_FETCH) rdata_d = data_in;
                end
            end
            TS_T3: begin
                if (op_q == OP_FETCH) begin
                    state_d = TS_T4;
                end else begin
                    state_d = TS_IDLE;
                    done_d  = 1'b1;
                    if (is_read(op_q)) rdata_d = data_in;
                end
            end
            TS_T4: begin
                state_d = TS_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = TS_IDLE;
        endcase
    end

    logic fetch, io, wr;
    assign fetch = (op_q == OP_FETCH);
    assign io    = is_io(op_q);
    assign wr    = is_write(op_q);

    always_comb begin
        ready    = (state_q == TS_IDLE);
        addr_oe  = 1'b0;
        addr_out = '0;
        data_oe  = 1'b0;
        data_out = '0;
        M1_L     = 1'b1;
        MREQ_L   = 1'b1;
        IORQ_L   = 1'b1;
        RD_L     = 1'b1;
        WR_L     = 1'b1;
        RFSH_L   = 1'b1;
        if (state_q != TS_IDLE) begin
            addr_oe  = 1'b1;
            addr_out = addr_q;
            data_oe  = wr;
            data_out = wr ? wdata_q : '0;
        end
        if (fetch && (state_q == TS_T3 || state_q == TS_T4)) begin
            // Refresh phase replaces the opcode address with {I,R}.
            addr_out = refresh_addr;
            MREQ_L   = 1'b0;
            RFSH_L   = 1'b0;
        end else if (state_q == TS_T1) begin
            if (!io) begin
                MREQ_L = 1'b0;
                RD_L   = wr;
                M1_L   = !fetch;
            end
        end else if (state_q == TS_T2 || state_q == TS_TW || state_q == TS_T3) begin
            MREQ_L = io;
            IORQ_L = !io;
            RD_L   = wr;
            WR_L   = !wr;
            M1_L   = !fetch;
        end
    end

    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Randomized scoreboard bench for z80_bus_sequencer: per-cycle bus expectations and
// per-transaction read data are queued by the driver and checked by an independent monitor.
module tb_z80_bus_sequencer;
    import z80_pkg::*;

    localparam int unsigned AUTO = 1;

    logic        CLK = 1'b0;
    logic        RESET_L = 1'b0;
    logic        req_valid = 1'b0;
    bus_op_t     req_op = OP_FETCH;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [15:0] refresh_addr = '0;
    logic        ready, done, data_oe, addr_oe;
    logic [7:0]  rdata, data_out;
    logic [15:0] addr_out;
    logic        WAIT_L = 1'b1;
    logic [7:0]  data_in = '0;
    logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

    always #5 CLK = ~CLK;

    z80_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .IO_AUTO_WAIT(AUTO)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .refresh_addr(refresh_addr),
        .ready(ready), .done(done), .rdata(rdata), .WAIT_L(WAIT_L), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .addr_out(addr_out), .addr_oe(addr_oe),
        .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .RFSH_L(RFSH_L)
    );

    typedef struct {
        logic        done, ready, addr_oe, data_oe;
        logic [5:0]  strb;  // {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    bus_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic       pending_done = 1'b0;
    logic [7:0] model_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L};
    endfunction

    function automatic bus_t exp_idle(input logic d);
        bus_t e;
        e.done = d; e.ready = 1'b1; e.addr_oe = 1'b0; e.data_oe = 1'b0;
        e.strb = 6'h3f; e.addr = '0; e.data = '0;
        return e;
    endfunction

    // ph: 1=T1 2=T2 3=TW 4=T3 5=T4
    function automatic bus_t exp_t(input bus_op_t op, input int ph, input logic [15:0] a,
                                   input logic [15:0] rf, input logic [7:0] wd);
        bus_t e;
        e = exp_idle(1'b0);
        e.ready = 1'b0; e.addr_oe = 1'b1; e.addr = a;
        e.data_oe = (op == OP_MEM_WR) || (op == OP_IO_WR);
        e.data = wd;
        if (op == OP_FETCH) begin
            if (ph <= 3) e.strb = 6'b001011;
            else begin e.strb = 6'b101110; e.addr = rf; end
        end else if (op == OP_MEM_RD) e.strb = 6'b101011;
        else if (op == OP_MEM_WR) e.strb = (ph >= 2) ? 6'b101101 : 6'b101111;
        else if (op == OP_IO_RD) e.strb = (ph >= 2) ? 6'b110011 : 6'b111111;
        else e.strb = (ph >= 2) ? 6'b110101 : 6'b111111;
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        bus_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bus_queue: got empty expected an entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("done", 32'(done), 32'(e.done));
                check("ready", 32'(ready), 32'(e.ready));
                check("addr_oe", 32'(addr_oe), 32'(e.addr_oe));
                check("data_oe", 32'(data_oe), 32'(e.data_oe));
                check("strobes", 32'(strobes()), 32'(e.strb));
                if (e.addr_oe) check("addr_out", 32'(addr_out), 32'(e.addr));
                if (e.data_oe) check("data_out", 32'(data_out), 32'(e.data));
            end
            if (done === 1'b1) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rdata_queue: got empty expected an entry at %0t", $time);
                end else begin
                    check("rdata", 32'(rdata), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input bus_t e, input logic rv, input bus_op_t op, input logic [15:0] a,
                        input logic [7:0] wd, input logic [15:0] rf, input logic w,
                        input logic [7:0] din);
        @(posedge CLK);
        #1;
        req_valid = rv; req_op = op; req_addr = a; req_wdata = wd;
        refresh_addr = rf; WAIT_L = w; data_in = din;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    function automatic bus_op_t rnd_op();
        return bus_op_t'($urandom_range(0, 4));
    endfunction

    task automatic run_txn(input bus_op_t op, input logic [15:0] a, input logic [7:0] wd,
                           input logic [15:0] rf, input int nw, input int gap, input int din);
        int aw, lat, wlo, ph;
        logic [7:0] d;
        logic wl;
        aw  = ((op == OP_IO_RD) || (op == OP_IO_WR)) ? int'(AUTO) : 0;
        lat = 4 + aw + nw + ((op == OP_FETCH) ? 1 : 0);
        wlo = 2 + aw;
        step(exp_idle(pending_done), 1'b1, op, a, wd, rf, 1'($urandom), 8'($urandom));
        pending_done = 1'b0;
        for (int k = 1; k < lat; k++) begin
            d = (din < 0) ? 8'($urandom) : 8'(din);
            if (k >= wlo && k < wlo + nw) wl = 1'b0;
            else if (k == wlo + nw) wl = 1'b1;
            else wl = 1'($urandom);
            if (k == 1) ph = 1;
            else if (k == 2) ph = 2;
            else if (k <= 2 + aw + nw) ph = 3;
            else if (k == 3 + aw + nw) ph = 4;
            else ph = 5;
            if (op == OP_FETCH && k == 2 + nw) model_rdata = d;
            if ((op == OP_MEM_RD || op == OP_IO_RD) && k == lat - 1) model_rdata = d;
            // Requests presented mid-cycle must be ignored.
            step(exp_t(op, ph, a, rf, wd), 1'($urandom), rnd_op(), 16'($urandom),
                 8'($urandom), rf, wl, d);
        end
        rd_q.push_back(model_rdata);
        pending_done = 1'b1;
        for (int g = 0; g < gap; g++) begin
            step(exp_idle(pending_done), 1'b0, rnd_op(), 16'($urandom), 8'($urandom),
                 16'($urandom), 1'($urandom), 8'($urandom));
            pending_done = 1'b0;
        end
    endtask

    initial begin
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'h3f);
        check("rst_oe", 32'({addr_oe, data_oe}), 32'd0);
        check("rst_addr_out", 32'(addr_out), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RESET_L = 1'b1;

        run_txn(OP_MEM_RD, 16'h1234, 8'h00, 16'h0000, 0, 1, 'hA5);
        run_txn(OP_MEM_WR, 16'h8000, 8'h3C, 16'h0000, 2, 0, -1);
        run_txn(OP_FETCH,  16'h0000, 8'h00, 16'h0A7F, 0, 1, 'hC3);
        run_txn(OP_IO_RD,  16'h00FE, 8'h00, 16'h0000, 0, 0, 'h5A);
        for (int i = 0; i < 80; i++)
            run_txn(rnd_op(), 16'($urandom), 8'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
        step(exp_idle(pending_done), 1'b0, OP_FETCH, '0, '0, '0, 1'b1, '0);
        pending_done = 1'b0;

        // Abort a memory write in TW with reset; no done may follow.
        step(exp_idle(1'b0), 1'b1, OP_MEM_WR, 16'h4321, 8'h77, '0, 1'b1, '0);
        step(exp_t(OP_MEM_WR, 1, 16'h4321, '0, 8'h77), 1'b0, OP_FETCH, '0, '0, '0, 1'b1, '0);
        step(exp_t(OP_MEM_WR, 2, 16'h4321, '0, 8'h77), 1'b0, OP_FETCH, '0, '0, '0, 1'b0, '0);
        step(exp_t(OP_MEM_WR, 3, 16'h4321, '0, 8'h77), 1'b0, OP_FETCH, '0, '0, '0, 1'b0, '0);
        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        check("bus_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rdata_queue_drained", 32'(rd_q.size()), 32'd0);
        RESET_L = 1'b0;
        #1;
        check("abort_strobes", 32'(strobes()), 32'h3f);
        check("abort_oe", 32'({addr_oe, data_oe}), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        @(posedge CLK);
        #1 RESET_L = 1'b1;
        WAIT_L = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_reset_ready", 32'(ready), 32'd1);
            check("post_reset_done", 32'(done), 32'd0);
            check("post_reset_strobes", 32'(strobes()), 32'h3f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
